register_file: RTL and testbench
================================

# register_file

Architectural integer register file for the RV32 core: the responder on the decode stage's two read-address/read-data ports and the consumer of its registered writeback packet `{write_bit, rd, result}`. Commits one write per cycle, holds x0 at zero, and optionally forwards the in-flight writeback to the read ports. Also provides a handshaked debug read port and a committed-write counter for trace and bring-up.

## Interface
- `XLEN`, 32, data width.
- `REG_AW`, 5, register address width; register count is 2**REG_AW.
- `i_clk`  in  1  core clock; all state updates on the rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `read_addr1`  in  REG_AW  read port 1 address.
- `read_addr2`  in  REG_AW  read port 2 address.
- `read_data1`  out  XLEN  read port 1 data, combinational.
- `read_data2`  out  XLEN  read port 2 data, combinational.
- `wb_reg`  in  XLEN+REG_AW+1  writeback packet: [MSB] write enable, next REG_AW bits rd, low XLEN bits data.
- `dbg_req`  in  1  debug read request.
- `dbg_addr`  in  REG_AW  debug read address, sampled on accept.
- `dbg_ready`  out  1  debug port can accept a request.
- `dbg_valid`  out  1  `dbg_data` holds a response.
- `dbg_data`  out  XLEN  debug response data.
- `dbg_ack`  in  1  consumer has taken the response.
- `wb_count`  out  32  number of committed writes.

## Operation
- Write: on each edge where we=1 and rd!=0, `regs[rd] <= data` and `wb_count` increments by 1. Packets with we=0 or rd=0 are ignored and not counted. `wb_count` wraps from 0xFFFF_FFFF to 0.
- Read: `read_dataN = (addrN==0) ? 0 : regs[addrN]`, subject to bypass (see Configuration). x0 always reads 0, including when bypass is enabled.
- Debug FSM, two states:
  - IDLE: `dbg_ready=1`. If `dbg_req` is high, capture `dbg_addr` and go to RESP.
  - RESP: `dbg_valid=1`, `dbg_ready=0`. `dbg_data` is held stable. `dbg_ack` returns to IDLE. Requests in RESP are ignored and not queued.
- Debug data is the post-edge value: when a write to the same address commits on the accept edge, the response returns the new data, regardless of the macro setting.
- The debug port never stalls or blocks writeback or the read ports.

## Timing
- Read ports: zero latency, purely combinational from address, `wb_reg`, and the array.
- Write: visible in the array on the cycle after the edge that commits it.
- Debug latency: `dbg_valid` is asserted the cycle after accept. In the minimum case, request-to-idle is 2 cycles (ack held high).
- Reset, asynchronous while `i_rst`=1:
  - all registers 0;
  - `wb_count`=0;
  - FSM in IDLE;
  - `dbg_valid`=0, `dbg_data`=0;
  - `dbg_ready`=0 while `i_rst` is high, and 1 from the first cycle after release.
- Reset mid-response drops the response; no ack is required.
- Simultaneous `dbg_ack` and `dbg_req` in RESP: return to IDLE; the new request is accepted next cycle at the earliest.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - a read port whose address equals the `wb_reg` rd, with we=1 and rd!=0, returns the `wb_reg` data in the same cycle;
  - port 1 and port 2 bypass independently; both may bypass together.
- Undefined: read ports return array contents only. The decode stage's own forwarding covers the hazard.

## Structure
- Shared core package holds:
  - `XLEN`/`REG_AW` constants;
  - the writeback packet struct (`we`, `rd`, `data`) with a width constant;
  - the debug FSM state enum `{DBG_IDLE, DBG_RESP}`.
- One sub-module, `regfile_dbg_port`: the debug FSM, address/data capture, and handshake. The array, write logic, read muxes, and `wb_count` stay in the top.

## Test plan
- Reset then write x5=0xDEAD_BEEF: next cycle, `read_addr1`=5 gives 0xDEAD_BEEF; `wb_count`=1.
- Write x0=0x1234 (we=1): `read_data1` for address 0 stays 0 with and without bypass; `wb_count` unchanged.
- With `REGFILE_BYPASS_EN`, `wb_reg`={1,7,0x55}, both read addresses 7: both read 0x55 the same cycle. Without the macro, both read the old x7 until the next cycle.
- Debug: `dbg_req` with `dbg_addr`=3 on the same edge as a commit of x3=0xA5: `dbg_valid` rises next cycle with `dbg_data`=0xA5, held through 3 cycles of no ack; `dbg_ack` returns `dbg_ready`=1 the following cycle.
- Preload `wb_count` via 2^32-1 commits (or force), one more commit: `wb_count`=0.
- Assert `i_rst` mid-RESP with x9 nonzero: `dbg_valid`=0, x9 reads 0, `dbg_ready`=0 during reset and 1 one cycle after release.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared core definitions for the RV32 integer register file: widths,
// writeback packet layout and debug-port FSM states.
package register_file_pkg;

    localparam int XLEN    = 32;
    localparam int REG_AW  = 5;
    localparam int REG_NUM = 2 ** REG_AW;
    localparam int WB_W    = XLEN + REG_AW + 1;

    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_pkt_t;

    typedef enum logic {
        DBG_IDLE = 1'b0,
        DBG_RESP = 1'b1
    } dbg_state_t;

    // A packet only changes architectural state when enabled and not aimed at x0.
    function automatic logic wb_commits(input logic we, input logic [REG_AW-1:0] rd);
        return we && (rd != {REG_AW{1'b0}});
    endfunction

endpackage

// File: rtl/register_file_dbg_port.sv
// Debug read port for the register file: one-deep request/response handshake
// that captures the post-edge register value on accept and holds it until acked.
module regfile_dbg_port
    import register_file_pkg::*;
#(
    parameter int DW = register_file_pkg::XLEN
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req,
    input  logic          i_ack,
    input  logic [DW-1:0] i_next_data,
    output logic          o_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data
);

    dbg_state_t    r_state;
    logic          r_ready;
    logic          r_valid;
    logic [DW-1:0] r_data;

    // r_ready stays low through reset and rises on the first edge after release,
    // so no request can be accepted before that edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= DBG_IDLE;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= {DW{1'b0}};
        end else begin
            case (r_state)
                DBG_IDLE: begin
                    if (r_ready && i_req) begin
                        r_state <= DBG_RESP;
                        r_data  <= i_next_data;
                        r_valid <= 1'b1;
                        r_ready <= 1'b0;
                    end else begin
                        r_state <= DBG_IDLE;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                DBG_RESP: begin
                    if (i_ack) begin
                        r_state <= DBG_IDLE;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_state <= DBG_RESP;
                        r_valid <= 1'b1;
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= DBG_IDLE;
                    r_valid <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/register_file.sv
// RV32 architectural register file: two combinational read ports, one
// writeback commit per cycle, committed-write counter and a debug read port.
// Optional same-cycle writeback forwarding is enabled by REGFILE_BYPASS_EN.
module register_file
    import register_file_pkg::*;
#(
    parameter int XLEN   = register_file_pkg::XLEN,
    parameter int REG_AW = register_file_pkg::REG_AW
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [REG_AW-1:0]      read_addr1,
    input  logic [REG_AW-1:0]      read_addr2,
    output logic [XLEN-1:0]        read_data1,
    output logic [XLEN-1:0]        read_data2,
    input  logic [XLEN+REG_AW:0]   wb_reg,
    input  logic                   dbg_req,
    input  logic [REG_AW-1:0]      dbg_addr,
    output logic                   dbg_ready,
    output logic                   dbg_valid,
    output logic [XLEN-1:0]        dbg_data,
    input  logic                   dbg_ack,
    output logic [31:0]            wb_count
);

    localparam int NREGS = 2 ** REG_AW;

    logic [XLEN-1:0]   r_regs [NREGS];
    logic [31:0]       r_wb_count;

    logic              w_wb_we;
    logic [REG_AW-1:0] w_wb_rd;
    logic [XLEN-1:0]   w_wb_data;
    logic              w_wb_commit;
    logic [XLEN-1:0]   w_rd1;
    logic [XLEN-1:0]   w_rd2;
    logic [XLEN-1:0]   w_dbg_next;

    assign w_wb_we     = wb_reg[XLEN+REG_AW];
    assign w_wb_rd     = wb_reg[XLEN+REG_AW-1:XLEN];
    assign w_wb_data   = wb_reg[XLEN-1:0];
    assign w_wb_commit = wb_commits(w_wb_we, w_wb_rd);

    // Architectural state: array commit and committed-write counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= {XLEN{1'b0}};
            end
            r_wb_count <= 32'd0;
        end else if (w_wb_commit) begin
            r_regs[w_wb_rd] <= w_wb_data;
            r_wb_count      <= r_wb_count + 32'd1;
        end else begin
            r_wb_count <= r_wb_count;
        end
    end

    // Read port 1; x0 wins over any forwarding.
    always_comb begin
        w_rd1 = {XLEN{1'b0}};
        if (read_addr1 == {REG_AW{1'b0}}) begin
            w_rd1 = {XLEN{1'b0}};
`ifdef REGFILE_BYPASS_EN
        end else if (w_wb_commit && (read_addr1 == w_wb_rd)) begin
            w_rd1 = w_wb_data;
`endif
        end else begin
            w_rd1 = r_regs[read_addr1];
        end
    end

    // Read port 2, independent of port 1.
    always_comb begin
        w_rd2 = {XLEN{1'b0}};
        if (read_addr2 == {REG_AW{1'b0}}) begin
            w_rd2 = {XLEN{1'b0}};
`ifdef REGFILE_BYPASS_EN
        end else if (w_wb_commit && (read_addr2 == w_wb_rd)) begin
            w_rd2 = w_wb_data;
`endif
        end else begin
            w_rd2 = r_regs[read_addr2];
        end
    end

    // Debug capture always sees the post-edge value, so it forwards unconditionally.
    always_comb begin
        w_dbg_next = {XLEN{1'b0}};
        if (dbg_addr == {REG_AW{1'b0}}) begin
            w_dbg_next = {XLEN{1'b0}};
        end else if (w_wb_commit && (dbg_addr == w_wb_rd)) begin
            w_dbg_next = w_wb_data;
        end else begin
            w_dbg_next = r_regs[dbg_addr];
        end
    end

    regfile_dbg_port #(
        .DW (XLEN)
    ) u_dbg_port (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (dbg_req),
        .i_ack       (dbg_ack),
        .i_next_data (w_dbg_next),
        .o_ready     (dbg_ready),
        .o_valid     (dbg_valid),
        .o_data      (dbg_data)
    );

    assign read_data1 = w_rd1;
    assign read_data2 = w_rd2;
    assign wb_count   = r_wb_count;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (default or bypass build).
module tb_register_file;

    logic        i_clk;
    logic        i_rst;
    logic [4:0]  read_addr1;
    logic [4:0]  read_addr2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [37:0] wb_reg;
    logic        dbg_req;
    logic [4:0]  dbg_addr;
    logic        dbg_ready;
    logic        dbg_valid;
    logic [31:0] dbg_data;
    logic        dbg_ack;
    logic [31:0] wb_count;

    int errors = 0;
    int checks = 0;

    register_file dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .read_addr1 (read_addr1),
        .read_addr2 (read_addr2),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .wb_reg     (wb_reg),
        .dbg_req    (dbg_req),
        .dbg_addr   (dbg_addr),
        .dbg_ready  (dbg_ready),
        .dbg_valid  (dbg_valid),
        .dbg_data   (dbg_data),
        .dbg_ack    (dbg_ack),
        .wb_count   (wb_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

`ifdef REGFILE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    initial begin
        i_rst      = 1'b1;
        read_addr1 = 5'd0;
        read_addr2 = 5'd0;
        wb_reg     = 38'd0;
        dbg_req    = 1'b0;
        dbg_addr   = 5'd0;
        dbg_ack    = 1'b0;

        #12;
        chk("rst_ready", {31'd0, dbg_ready}, 32'd0);
        chk("rst_valid", {31'd0, dbg_valid}, 32'd0);
        chk("rst_data", dbg_data, 32'd0);
        chk("rst_count", wb_count, 32'd0);

        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        chk("ready_before_edge", {31'd0, dbg_ready}, 32'd0);
        tick();
        chk("ready_after_release", {31'd0, dbg_ready}, 32'd1);

        // x5 = DEADBEEF
        wb_reg     = {1'b1, 5'd5, 32'hDEAD_BEEF};
        read_addr1 = 5'd5;
        #1;
        chk("x5_same_cycle", read_data1, BYP ? 32'hDEAD_BEEF : 32'd0);
        tick();
        wb_reg = 38'd0;
        #1;
        chk("x5_read", read_data1, 32'hDEAD_BEEF);
        chk("count_1", wb_count, 32'd1);

        // write to x0 is dropped
        wb_reg     = {1'b1, 5'd0, 32'h0000_1234};
        read_addr1 = 5'd0;
        read_addr2 = 5'd5;
        #1;
        chk("x0_same_cycle", read_data1, 32'd0);
        chk("port2_x5", read_data2, 32'hDEAD_BEEF);
        tick();
        wb_reg = 38'd0;
        #1;
        chk("x0_after", read_data1, 32'd0);
        chk("count_x0_ignored", wb_count, 32'd1);

        // we=0 is dropped
        wb_reg = {1'b0, 5'd7, 32'h0000_00EE};
        tick();
        wb_reg = 38'd0;
        read_addr1 = 5'd7;
        #1;
        chk("we0_ignored", read_data1, 32'd0);
        chk("count_we0", wb_count, 32'd1);

        // dual-port bypass on x7
        wb_reg = {1'b1, 5'd7, 32'h0000_0011};
        tick();
        wb_reg     = {1'b1, 5'd7, 32'h0000_0055};
        read_addr1 = 5'd7;
        read_addr2 = 5'd7;
        #1;
        chk("byp_port1", read_data1, BYP ? 32'h55 : 32'h11);
        chk("byp_port2", read_data2, BYP ? 32'h55 : 32'h11);
        tick();
        wb_reg = 38'd0;
        #1;
        chk("x7_port1", read_data1, 32'h55);
        chk("x7_port2", read_data2, 32'h55);
        chk("count_3", wb_count, 32'd3);

        // debug accept on same edge as commit to x3
        wb_reg   = {1'b1, 5'd3, 32'h0000_00A5};
        dbg_req  = 1'b1;
        dbg_addr = 5'd3;
        #1;
        chk("dbg_ready_idle", {31'd0, dbg_ready}, 32'd1);
        chk("dbg_valid_idle", {31'd0, dbg_valid}, 32'd0);
        tick();
        wb_reg  = {1'b1, 5'd3, 32'h0000_00FF};
        dbg_req = 1'b1;
        #1;
        chk("dbg_valid_1", {31'd0, dbg_valid}, 32'd1);
        chk("dbg_data_1", dbg_data, 32'hA5);
        chk("dbg_ready_resp", {31'd0, dbg_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            wb_reg = 38'd0;
            #1;
            chk("dbg_hold_valid", {31'd0, dbg_valid}, 32'd1);
            chk("dbg_hold_data", dbg_data, 32'hA5);
        end
        dbg_ack = 1'b1;
        dbg_req = 1'b1;
        tick();
        dbg_ack = 1'b0;
        #1;
        chk("ack_valid", {31'd0, dbg_valid}, 32'd0);
        chk("ack_ready", {31'd0, dbg_ready}, 32'd1);
        tick();
        dbg_req = 1'b0;
        #1;
        chk("reaccept_valid", {31'd0, dbg_valid}, 32'd1);
        chk("reaccept_data", dbg_data, 32'hFF);
        dbg_ack = 1'b1;
        tick();
        dbg_ack = 1'b0;
        #1;
        chk("idle_again", {31'd0, dbg_ready}, 32'd1);
        chk("count_5", wb_count, 32'd5);

        // counter wrap
        force dut.r_wb_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_wb_count;
        #1;
        chk("count_preload", wb_count, 32'hFFFF_FFFF);
        wb_reg = {1'b1, 5'd10, 32'h0000_0001};
        tick();
        wb_reg = 38'd0;
        #1;
        chk("count_wrap", wb_count, 32'd0);

        // reset during a response
        wb_reg = {1'b1, 5'd9, 32'h0000_0099};
        tick();
        wb_reg     = 38'd0;
        read_addr1 = 5'd9;
        dbg_req    = 1'b1;
        dbg_addr   = 5'd9;
        #1;
        chk("x9_written", read_data1, 32'h99);
        tick();
        dbg_req = 1'b0;
        #1;
        chk("x9_dbg", dbg_data, 32'h99);
        i_rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, dbg_valid}, 32'd0);
        chk("mid_rst_data", dbg_data, 32'd0);
        chk("mid_rst_ready", {31'd0, dbg_ready}, 32'd0);
        chk("mid_rst_x9", read_data1, 32'd0);
        chk("mid_rst_count", wb_count, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        chk("rel_ready_low", {31'd0, dbg_ready}, 32'd0);
        tick();
        chk("rel_ready_high", {31'd0, dbg_ready}, 32'd1);
        chk("rel_valid", {31'd0, dbg_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
